// File: rtl/xga_mem_pkg.sv
// Shared types for the xga SDRAM command path: the 41-bit single-word memory command
// and the client identifiers carried in the outstanding-read tag FIFO.
package xga_mem_pkg;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } mem_cmd_t;

  localparam logic CLIENT_DISPLAY = 1'b0;
  localparam logic CLIENT_GENERAL = 1'b1;

endpackage

// File: rtl/order_fifo.sv
// 1-bit-wide synchronous FIFO holding the issuing client of each outstanding read.
// Depth must be a power of two, 2 or more; the head is combinational.
module order_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Depth-1:0] mem_q;
  logic [AddrW:0]   wr_q, wr_d;
  logic [AddrW:0]   rd_q, rd_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign data_o  = mem_q[rd_q[AddrW-1:0]];

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wr_d    = do_push ? wr_q + (AddrW + 1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AddrW + 1)'(1) : rd_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Two-client arbiter for the single-word SDRAM command path: fixed priority to the display
// client with a starvation limit, plus in-order steering of read responses by issuing client.
module mem_cmd_arbiter
  import xga_mem_pkg::*;
#(
  parameter int unsigned MAX_HOLD    = 4,
  parameter int unsigned ORDER_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        c0_cmd_valid_i,
  output logic        c0_cmd_ready_o,
  input  logic [40:0] c0_cmd_i,
  input  logic        c1_cmd_valid_i,
  output logic        c1_cmd_ready_o,
  input  logic [40:0] c1_cmd_i,
  output logic        c0_rsp_valid_o,
  input  logic        c0_rsp_ready_i,
  output logic [15:0] c0_rsp_data_o,
  output logic        c1_rsp_valid_o,
  input  logic        c1_rsp_ready_i,
  output logic [15:0] c1_rsp_data_o,
  output logic [40:0] writer_d_o,
  output logic        writer_enq_o,
  input  logic        writer_full_i,
  input  logic [15:0] reader_q_i,
  output logic        reader_deq_o,
  input  logic        reader_empty_i,
  output logic        rsp_orphan_o
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  mem_cmd_t         c0_cmd, c1_cmd;
  logic             c0_elig, c1_elig, grant0, grant1, hold_max;
  logic             tag_full, tag_empty, tag_head, tag_push, tag_pop, tag_id;
  logic             rsp_avail, c0_rsp_v, c1_rsp_v;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             orphan_q, orphan_d;

  assign c0_cmd = mem_cmd_t'(c0_cmd_i);
  assign c1_cmd = mem_cmd_t'(c1_cmd_i);

  always_comb begin
    hold_max = (hold_q == HoldW'(MAX_HOLD));
    c0_elig  = ~reset_i & c0_cmd_valid_i & ~writer_full_i & (c0_cmd.we | ~tag_full);
    c1_elig  = ~reset_i & c1_cmd_valid_i & ~writer_full_i & (c1_cmd.we | ~tag_full);
    grant1   = c1_elig & (~c0_elig | hold_max);
    grant0   = c0_elig & ~grant1;
    tag_push = (grant0 & ~c0_cmd.we) | (grant1 & ~c1_cmd.we);
    tag_id   = grant1 ? CLIENT_GENERAL : CLIENT_DISPLAY;
  end

  assign c0_cmd_ready_o = grant0;
  assign c1_cmd_ready_o = grant1;
  assign writer_enq_o   = grant0 | grant1;
  assign writer_d_o     = grant1 ? c1_cmd : c0_cmd;

  always_comb begin
    rsp_avail = ~reset_i & ~tag_empty & ~reader_empty_i;
    c0_rsp_v  = rsp_avail & (tag_head == CLIENT_DISPLAY);
    c1_rsp_v  = rsp_avail & (tag_head == CLIENT_GENERAL);
    tag_pop   = (c0_rsp_v & c0_rsp_ready_i) | (c1_rsp_v & c1_rsp_ready_i);
  end

  assign c0_rsp_valid_o = c0_rsp_v;
  assign c1_rsp_valid_o = c1_rsp_v;
  assign c0_rsp_data_o  = reader_q_i;
  assign c1_rsp_data_o  = reader_q_i;
  assign reader_deq_o   = tag_pop;
  assign rsp_orphan_o   = orphan_q;

  // Only a display grant taken while the general client waits counts toward starvation.
  always_comb begin
    hold_d = hold_q;
    if (grant0 && c1_cmd_valid_i) begin
      if (!hold_max) begin
        hold_d = hold_q + HoldW'(1);
      end
    end else if (grant0 || grant1) begin
      hold_d = '0;
    end
    orphan_d = orphan_q | (~reader_empty_i & tag_empty);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hold_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      orphan_q <= orphan_d;
    end
  end

  order_fifo #(
    .Depth (ORDER_DEPTH)
  ) u_order_fifo (
    .clk_i   (clk),
    .rst_i   (reset_i),
    .push_i  (tag_push),
    .data_i  (tag_id),
    .pop_i   (tag_pop),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

endmodule
